// File: rtl/regfile_alu_pipe_if.sv
// Instruction/result bus of regfile_alu_pipe: one instruction channel in, one result channel out.
// Both channels: a beat transfers on a rising clk edge where valid & ready; a held beat stays stable.
interface regfile_alu_pipe_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [AW-1:0]    in_rd;
   logic [AW-1:0]    in_rs1;
   logic [AW-1:0]    in_rs2;
   logic [WIDTH-1:0] in_imm;

   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_rd;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_rd, out_data, out_carry
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_rd, out_data, out_carry
   );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Register file + two-operand ALU in a 2-stage (E, R) pipeline with a carry flag.
// Optional macro REGFILE_ALU_FWD_EN: bypass the E result into issue instead of stalling.
module regfile_alu_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   regfile_alu_pipe_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_LDI  = 3'b101;
   localparam logic [2:0] OP_ADDC = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   logic [WIDTH-1:0] rf [DEPTH];
   logic             c;

   logic             e_valid;
   logic [2:0]       e_op;
   logic [AW-1:0]    e_rd;
   logic [WIDTH-1:0] e_a;
   logic [WIDTH-1:0] e_b;
   logic [WIDTH-1:0] e_imm;
   logic             e_c;

   logic             r_valid;
   logic [AW-1:0]    r_rd;
   logic [WIDTH-1:0] r_data;
   logic             r_carry;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] e_res;
   logic             e_res_c;
   logic             e_writes;
   logic             e_sets_c;
   logic             e_adv;
   logic             hazard_stall;
   logic             fire;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic             rd_c;

   // One shared WIDTH+1 adder: SUB is a + ~b + 1, ADDC injects the latched carry.
   always_comb begin
      add_b   = e_b;
      add_cin = 1'b0;
      if (e_op == OP_SUB) begin
         add_b   = ~e_b;
         add_cin = 1'b1;
      end else if (e_op == OP_ADDC) begin
         add_cin = e_c;
      end
      sum = {1'b0, e_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
   end

   // Carry-preserving ops report the live flag: every older instruction has already
   // written back by the time this one sits in E, so c is architecturally current.
   always_comb begin
      e_res   = '0;
      e_res_c = c;
      case (e_op)
         OP_ADD, OP_SUB, OP_ADDC: begin
            e_res   = sum[WIDTH-1:0];
            e_res_c = sum[WIDTH];
         end
         OP_AND:  e_res = e_a & e_b;
         OP_OR:   e_res = e_a | e_b;
         OP_XOR:  e_res = e_a ^ e_b;
         OP_LDI:  e_res = e_imm;
         default: e_res = '0;
      endcase
   end

   assign e_writes = e_valid & (e_op != OP_NOP);
   assign e_sets_c = e_valid & ((e_op == OP_ADD) | (e_op == OP_SUB) | (e_op == OP_ADDC));
   assign e_adv    = e_valid & (~r_valid | bus.out_ready);

`ifdef REGFILE_ALU_FWD_EN
   // Issue only happens while E is empty or advancing, so the bypass is always the committed value.
   always_comb begin
      rd_a = rf[bus.in_rs1];
      rd_b = rf[bus.in_rs2];
      rd_c = c;
      if (e_writes && (bus.in_rs1 == e_rd)) rd_a = e_res;
      if (e_writes && (bus.in_rs2 == e_rd)) rd_b = e_res;
      if (e_sets_c) rd_c = e_res_c;
   end
   assign hazard_stall = 1'b0;
`else
   assign rd_a = rf[bus.in_rs1];
   assign rd_b = rf[bus.in_rs2];
   assign rd_c = c;
   assign hazard_stall = (e_writes & ((bus.in_rs1 == e_rd) | (bus.in_rs2 == e_rd)))
                       | ((bus.in_op == OP_ADDC) & e_sets_c);
`endif

   assign bus.in_ready = (~e_valid | e_adv) & ~hazard_stall;
   assign fire         = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid <= 1'b0;
         e_op    <= OP_NOP;
         e_rd    <= '0;
         e_a     <= '0;
         e_b     <= '0;
         e_imm   <= '0;
         e_c     <= 1'b0;
      end else if (fire) begin
         e_valid <= 1'b1;
         e_op    <= bus.in_op;
         e_rd    <= bus.in_rd;
         e_a     <= rd_a;
         e_b     <= rd_b;
         e_imm   <= bus.in_imm;
         e_c     <= rd_c;
      end else if (e_adv) begin
         e_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
         r_carry <= 1'b0;
      end else if (e_adv) begin
         r_valid <= 1'b1;
         r_rd    <= e_rd;
         r_data  <= e_res;
         r_carry <= e_res_c;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
         c <= 1'b0;
      end else begin
         if (e_adv && e_writes) rf[e_rd] <= e_res;
         if (e_adv && e_sets_c) c <= e_res_c;
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.out_rd    = r_rd;
   assign bus.out_data  = r_data;
   assign bus.out_carry = r_carry;
endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Bench for regfile_alu_pipe: directed scenarios plus random traffic against an architectural model.
// Build with +define+REGFILE_ALU_FWD_EN to exercise the bypass variant.
module tb_regfile_alu_pipe;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3;
  localparam logic [2:0] XOR = 3'd4, LDI = 3'd5, ADDC = 3'd6, NOP = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_alu_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regfile_alu_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic rand_ready   = 1'b0;
  logic forced_ready = 1'b1;
  logic rnd_bit      = 1'b1;
  bit   chk_lat      = 1'b0;

  assign bus.out_ready = rand_ready ? rnd_bit : forced_ready;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  // ---------------- reference model + scoreboard ----------------
  logic [WIDTH-1:0]  m_rf [DEPTH];
  logic              m_c;
  logic [WIDTH+AW:0] exp_q [$];   // {rd, carry, data}
  int                iss_q [$];

  logic [AW-1:0]     last_rd;
  logic [WIDTH-1:0]  last_data;
  logic              last_carry;
  logic [WIDTH+AW:0] mon_e;
  int                mon_li;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
    m_c = 1'b0;
    exp_q.delete();
    iss_q.delete();
  endtask

  task automatic model_issue(input logic [2:0] op, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [WIDTH-1:0] imm);
    logic [WIDTH-1:0] a, b, r;
    logic [WIDTH:0]   t;
    logic             cc;
    a  = m_rf[rs1];
    b  = m_rf[rs2];
    cc = m_c;
    r  = '0;
    case (op)
      ADD:  begin t = a + b;        r = t[WIDTH-1:0]; cc = t[WIDTH]; end
      SUB:  begin r = a - b;        cc = (a >= b); end
      ADDC: begin t = a + b + m_c;  r = t[WIDTH-1:0]; cc = t[WIDTH]; end
      AND:  r = a & b;
      OR:   r = a | b;
      XOR:  r = a ^ b;
      LDI:  r = imm;
      default: r = '0;
    endcase
    if (op != NOP) m_rf[rd] = r;
    m_c = cc;
    exp_q.push_back({rd, cc, r});
    iss_q.push_back(cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      model_issue(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(bus.out_valid), 64'(0));
      end else begin
        mon_e  = exp_q.pop_front();
        mon_li = iss_q.pop_front();
        check("out_rd",    64'(bus.out_rd),    64'(mon_e[WIDTH+AW:WIDTH+1]));
        check("out_carry", 64'(bus.out_carry), 64'(mon_e[WIDTH]));
        check("out_data",  64'(bus.out_data),  64'(mon_e[WIDTH-1:0]));
        if (chk_lat) check("latency", 64'(cyc - mon_li), 64'(2));
      end
      last_rd    = bus.out_rd;
      last_data  = bus.out_data;
      last_carry = bus.out_carry;
    end
  end

  // ---------------- driver tasks (all return at posedge+1) ----------------
  task automatic set_instr(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                           input logic [WIDTH-1:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd[AW-1:0];
    bus.in_rs1   = rs1[AW-1:0];
    bus.in_rs2   = rs2[AW-1:0];
    bus.in_imm   = imm;
  endtask

  task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                       input logic [WIDTH-1:0] imm, output int waits);
    bit done = 1'b0;
    waits = 0;
    set_instr(op, rd, rs1, rs2, imm);
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else begin
        waits++;
        if (waits > 64) begin
          check("accept_timeout", 64'(0), 64'(1));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic expect_last(input string tag, input int rd, input logic [WIDTH-1:0] data,
                             input logic carry);
    check({tag, "_rd"},    64'(last_rd),    64'(rd));
    check({tag, "_data"},  64'(last_data),  64'(data));
    check({tag, "_carry"}, 64'(last_carry), 64'(carry));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int w;
    int exp_stall;
    bus.in_valid = 1'b0;
    bus.in_op    = NOP;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    last_rd = '0; last_data = '0; last_carry = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("init_in_ready",  64'(bus.in_ready),  64'(1));
    check("init_out_valid", 64'(bus.out_valid), 64'(0));
    check("init_out_data",  64'(bus.out_data),  64'(0));

    // 1: reset with two instructions in flight
    forced_ready = 1'b0;
    issue(LDI, 5, 0, 0, 32'h1234_5678, w);
    issue(LDI, 6, 0, 0, 32'h0BAD_F00D, w);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  64'(bus.out_data),  64'(0));
    check("rst_out_rd",    64'(bus.out_rd),    64'(0));
    check("rst_out_carry", 64'(bus.out_carry), 64'(0));
    model_reset();
    forced_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 64'(bus.in_ready), 64'(1));
    last_rd = 3'd7; last_data = 32'hFFFF_FFFF; last_carry = 1'b1;
    issue(ADD, 0, 1, 2, '0, w);
    drain();
    expect_last("t1_add", 0, 32'h0000_0000, 1'b0);
    idle(2);
    check("t1_no_stale_out", 64'(bus.out_valid), 64'(0));

    // 2: loads then dependent add, latency checked per result
    chk_lat = 1'b1;
    issue(LDI, 0, 0, 0, 32'hDEAD_BEEF, w);
    issue(LDI, 1, 0, 0, 32'hBEEF_DEAD, w);
    issue(ADD, 2, 0, 1, '0, w);
    drain();
    expect_last("t2_add", 2, 32'h9D9D_9D9C, 1'b1);

    // 3: carry out of ADD, consumed by ADDC
    issue(LDI, 3, 0, 0, 32'hFFFF_FFFF, w);
    issue(LDI, 4, 0, 0, 32'h0000_0001, w);
    issue(ADD, 5, 3, 4, '0, w);
    drain();
    expect_last("t3_add", 5, 32'h0000_0000, 1'b1);
    issue(ADDC, 6, 4, 4, '0, w);
    drain();
    expect_last("t3_addc", 6, 32'h0000_0003, 1'b0);

    // 4: subtraction borrow / no-borrow
    issue(SUB, 7, 4, 3, '0, w);
    drain();
    expect_last("t4_sub_borrow", 7, 32'h0000_0002, 1'b0);
    issue(SUB, 7, 3, 4, '0, w);
    drain();
    expect_last("t4_sub_nob", 7, 32'hFFFF_FFFE, 1'b1);
    issue(LDI, 1, 0, 0, 32'h0000_0042, w);
    drain();
    expect_last("t4_ldi_keeps_c", 1, 32'h0000_0042, 1'b1);
    chk_lat = 1'b0;

    // 5: backpressure with three independent loads
    forced_ready = 1'b0;
    issue(LDI, 1, 0, 0, 32'hAAAA_0001, w);
    check("bp_acc1_wait", 64'(w), 64'(0));
    issue(LDI, 2, 0, 0, 32'hAAAA_0002, w);
    check("bp_acc2_wait", 64'(w), 64'(0));
    set_instr(LDI, 3, 0, 0, 32'hAAAA_0003);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready",  64'(bus.in_ready),  64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_out_data",  64'(bus.out_data),  64'(32'hAAAA_0001));
      @(posedge clk); #1;
    end
    forced_ready = 1'b1;
    issue(LDI, 3, 0, 0, 32'hAAAA_0003, w);
    check("bp_acc3_wait", 64'(w), 64'(0));
    drain();
    expect_last("t5_last", 3, 32'hAAAA_0003, 1'b1);

    // 6: dependent back-to-back
`ifdef REGFILE_ALU_FWD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif
    issue(LDI, 1, 0, 0, 32'd5, w);
    issue(ADD, 2, 1, 1, '0, w);
    check("dep_stall_cycles", 64'(w), 64'(exp_stall));
    drain();
    expect_last("t6_add", 2, 32'h0000_000A, 1'b0);

    // random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
            $urandom_range(0, DEPTH - 1), $urandom(), w);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();
    rand_ready = 1'b0;

    // read every register back through OR rk = rk | rk
    for (int k = 0; k < DEPTH; k++) issue(OR, k, k, k, '0, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
